reg_file_psr: RTL and testbench

- Parametrised successor to the 16x16 register file and processor status register.
- Provides a generic-width, generic-depth register file with one write port and two combinational read ports.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for multi-cycle producers (loads), and a flag register with per-bit masked update.
- Sits between the decoder/ALU and the writeback mux of the datapath.

---
 rtl/reg_file_psr_if.sv | 44 ++++
 rtl/reg_file_psr.sv | 98 +++++++++
 tb/tb_reg_file_psr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_psr_if.sv
// reg_file_psr_if: bus bundle between the datapath and the register file / PSR.
//   master : decoder/ALU side, drives write, read-address, scoreboard and flag inputs
//   slave  : reg_file_psr, returns read data, busy status and current flags
// Signals:
//   regWrite/wrAddr/wrData        register write port
//   sourceAddr/destAddr           read port addresses
//   readData1/readData2           read port data (combinational, write-bypassed)
//   busySet/busyAddr              mark a register as having a pending producer
//   srcBusy/dstBusy               pending-producer status of the read addresses
//   flagWrite/flagMask/flags      masked PSR update
//   readFlags                     current PSR contents
interface reg_file_psr_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FLAG_W = 5
);
  logic              regWrite;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic [ADDR_W-1:0] sourceAddr;
  logic [ADDR_W-1:0] destAddr;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;
  logic              busySet;
  logic [ADDR_W-1:0] busyAddr;
  logic              srcBusy;
  logic              dstBusy;
  logic              flagWrite;
  logic [FLAG_W-1:0] flagMask;
  logic [FLAG_W-1:0] flags;
  logic [FLAG_W-1:0] readFlags;

  modport master (
    output regWrite, wrAddr, wrData, sourceAddr, destAddr,
    output busySet, busyAddr, flagWrite, flagMask, flags,
    input  readData1, readData2, srcBusy, dstBusy, readFlags
  );

  modport slave (
    input  regWrite, wrAddr, wrData, sourceAddr, destAddr,
    input  busySet, busyAddr, flagWrite, flagMask, flags,
    output readData1, readData2, srcBusy, dstBusy, readFlags
  );
endinterface

// File: rtl/reg_file_psr.sv
// reg_file_psr: 2**ADDR_W x WIDTH register file (1 write, 2 combinational read
// ports with same-cycle write bypass), per-register busy scoreboard for
// multi-cycle producers, and a FLAG_W-bit processor status register with
// per-bit masked update.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; clears registers, busy bits and PSR
//   bus    reg_file_psr_if.slave (see interface file for signal list)
// Optional feature macro: ZERO_REG_EN -- register 0 reads as zero, ignores
// writes and can never be marked busy.
module reg_file_psr #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FLAG_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_psr_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic wr_en_c, busy_set_c;
  logic src_hit_c, dst_hit_c;
  logic src_zero_c, dst_zero_c;

  // Qualify write/busy-set against the hardwired zero register.
  always_comb begin
    wr_en_c    = bus.regWrite & ~(ZERO_REG & (bus.wrAddr == '0));
    busy_set_c = bus.busySet  & ~(ZERO_REG & (bus.busyAddr == '0));
    src_hit_c  = bus.regWrite & (bus.wrAddr == bus.sourceAddr);
    dst_hit_c  = bus.regWrite & (bus.wrAddr == bus.destAddr);
    src_zero_c = ZERO_REG & (bus.sourceAddr == '0);
    dst_zero_c = ZERO_REG & (bus.destAddr == '0);
  end

  // Next state: write, scoreboard (set applied after clear so set wins), PSR merge.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    flags_d = flags_q;
    if (wr_en_c) begin
      regs_d[bus.wrAddr] = bus.wrData;
    end
    if (bus.regWrite) begin
      busy_d[bus.wrAddr] = 1'b0;
    end
    if (busy_set_c) begin
      busy_d[bus.busyAddr] = 1'b1;
    end
    if (bus.flagWrite) begin
      flags_d = (flags_q & ~bus.flagMask) | (bus.flags & bus.flagMask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      flags_q <= flags_d;
    end
  end

  // Combinational read ports; the zero register masks even the bypass path.
  always_comb begin
    bus.readData1 = '0;
    bus.readData2 = '0;
    if (!src_zero_c) begin
      bus.readData1 = src_hit_c ? bus.wrData : regs_q[bus.sourceAddr];
    end
    if (!dst_zero_c) begin
      bus.readData2 = dst_hit_c ? bus.wrData : regs_q[bus.destAddr];
    end
  end

  // A completing write releases its reader in the same cycle as the bypass.
  always_comb begin
    bus.srcBusy   = busy_q[bus.sourceAddr] & ~src_hit_c;
    bus.dstBusy   = busy_q[bus.destAddr]   & ~dst_hit_c;
    bus.readFlags = flags_q;
  end

endmodule

// File: tb/tb_reg_file_psr.sv
// tb_reg_file_psr: directed bench for reg_file_psr with an array-based
// reference model compared on every falling edge, plus literal expectations.
module tb_reg_file_psr;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned DEPTH  = 16;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_file_psr_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) bus ();

  reg_file_psr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FLAG_W(FLAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [WIDTH-1:0]  m_regs [DEPTH];
  logic              m_busy [DEPTH];
  logic [FLAG_W-1:0] m_flags;
  bit                m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the active edge from the inputs held during the cycle.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
      m_flags <= '0;
      m_valid <= 1'b1;
    end else begin
      if (bus.regWrite && !(ZR && bus.wrAddr == 4'd0)) m_regs[bus.wrAddr] <= bus.wrData;
      if (bus.regWrite) m_busy[bus.wrAddr] <= 1'b0;
      if (bus.busySet && !(ZR && bus.busyAddr == 4'd0)) m_busy[bus.busyAddr] <= 1'b1;
      if (bus.flagWrite) begin
        for (int b = 0; b < FLAG_W; b++) begin
          if (bus.flagMask[b]) m_flags[b] <= bus.flags[b];
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (ZR && a == 4'd0) return '0;
    if (bus.regWrite && bus.wrAddr == a) return bus.wrData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (bus.regWrite && bus.wrAddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rd1",   32'(bus.readData1), 32'(exp_rd(bus.sourceAddr)));
      chk("model_rd2",   32'(bus.readData2), 32'(exp_rd(bus.destAddr)));
      chk("model_sbusy", 32'(bus.srcBusy),   32'(exp_busy(bus.sourceAddr)));
      chk("model_dbusy", 32'(bus.dstBusy),   32'(exp_busy(bus.destAddr)));
      chk("model_flags", 32'(bus.readFlags), 32'(m_flags));
    end
  end

  // Present one cycle of inputs, return at the falling edge of that cycle.
  task automatic cyc(input logic rst, input logic rw, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [3:0] sa, input logic [3:0] da,
                     input logic bs, input logic [3:0] ba, input logic fw,
                     input logic [4:0] fm, input logic [4:0] fl);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.regWrite   = rw;
    bus.wrAddr     = wa;
    bus.wrData     = wd;
    bus.sourceAddr = sa;
    bus.destAddr   = da;
    bus.busySet    = bs;
    bus.busyAddr   = ba;
    bus.flagWrite  = fw;
    bus.flagMask   = fm;
    bus.flags      = fl;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] sa, input logic [3:0] da);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, sa, da, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    bus.regWrite = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.sourceAddr = '0; bus.destAddr = '0; bus.busySet = 1'b0; bus.busyAddr = '0;
    bus.flagWrite = 1'b0; bus.flagMask = '0; bus.flags = '0;

    // Reset then read.
    cyc(1'b1, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    rd(4'd5, 4'd9);
    chk("rst_rd1", 32'(bus.readData1), 32'h0);
    chk("rst_rd2", 32'(bus.readData2), 32'h0);
    chk("rst_flags", 32'(bus.readFlags), 32'h0);
    chk("rst_sbusy", 32'(bus.srcBusy), 32'h0);
    chk("rst_dbusy", 32'(bus.dstBusy), 32'h0);

    // Write with same-cycle bypass, then stored value.
    cyc(1'b0, 1'b1, 4'd1, 16'd5, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("byp_r1", 32'(bus.readData1), 32'd5);
    rd(4'd1, 4'd0);
    chk("stored_r1", 32'(bus.readData1), 32'd5);
    cyc(1'b0, 1'b1, 4'd2, 16'd4, 4'd0, 4'd2, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("byp_r2", 32'(bus.readData2), 32'd4);
    rd(4'd0, 4'd2);
    chk("stored_r2", 32'(bus.readData2), 32'd4);
    cyc(1'b0, 1'b1, 4'd3, 16'd2, 4'd0, 4'd3, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("byp_r3", 32'(bus.readData2), 32'd2);
    rd(4'd1, 4'd3);
    chk("stored_r3", 32'(bus.readData2), 32'd2);
    chk("stored_r1b", 32'(bus.readData1), 32'd5);

    // Scoreboard set, then completing write un-stalls the reader.
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 4'd7, 4'd0, 1'b1, 4'd7, 1'b0, 5'd0, 5'd0);
    chk("busy_not_yet", 32'(bus.srcBusy), 32'h0);
    rd(4'd7, 4'd7);
    chk("busy7_src", 32'(bus.srcBusy), 32'h1);
    chk("busy7_dst", 32'(bus.dstBusy), 32'h1);
    cyc(1'b0, 1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("busy7_release", 32'(bus.srcBusy), 32'h0);
    chk("busy7_byp", 32'(bus.readData1), 32'hBEEF);
    rd(4'd7, 4'd0);
    chk("busy7_clear", 32'(bus.srcBusy), 32'h0);
    chk("r7_stored", 32'(bus.readData1), 32'hBEEF);

    // Set and clear to the same address: set wins, data still written.
    cyc(1'b0, 1'b1, 4'd4, 16'h0011, 4'd0, 4'd4, 1'b1, 4'd4, 1'b0, 5'd0, 5'd0);
    chk("coll_byp", 32'(bus.readData2), 32'h0011);
    rd(4'd0, 4'd4);
    chk("coll_data", 32'(bus.readData2), 32'h0011);
    chk("coll_busy", 32'(bus.dstBusy), 32'h1);

    // Set and clear to different addresses: both apply.
    cyc(1'b0, 1'b1, 4'd4, 16'h0022, 4'd0, 4'd0, 1'b1, 4'd8, 1'b0, 5'd0, 5'd0);
    rd(4'd8, 4'd4);
    chk("diff_set", 32'(bus.srcBusy), 32'h1);
    chk("diff_clr", 32'(bus.dstBusy), 32'h0);
    chk("diff_data", 32'(bus.readData2), 32'h0022);

    // Both ports on the register being written.
    cyc(1'b0, 1'b1, 4'd3, 16'h0077, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("dual_byp1", 32'(bus.readData1), 32'h0077);
    chk("dual_byp2", 32'(bus.readData2), 32'h0077);

    // Masked PSR update, no bypass.
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'b00101, 5'b11111);
    chk("psr_nobyp", 32'(bus.readFlags), 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'b00001, 5'b00000);
    chk("psr_first", 32'(bus.readFlags), 32'b00101);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'b00000, 5'b11111);
    chk("psr_second", 32'(bus.readFlags), 32'b00100);
    rd(4'd0, 4'd0);
    chk("psr_mask0", 32'(bus.readFlags), 32'b00100);

    // Register 0 behaviour depends on the build option.
    cyc(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0);
    chk("r0_byp", 32'(bus.readData1), ZR ? 32'h0 : 32'hFFFF);
    rd(4'd0, 4'd0);
    chk("r0_stored", 32'(bus.readData1), ZR ? 32'h0 : 32'hFFFF);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 5'd0, 5'd0);
    rd(4'd0, 4'd0);
    chk("r0_busy", 32'(bus.srcBusy), ZR ? 32'h0 : 32'h1);

    // Pseudo-random traffic checked by the model only.
    for (int n = 0; n < 60; n++) begin
      cyc(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
    end

    // Reset mid-operation overrides write, busy set and flag write.
    cyc(1'b0, 1'b1, 4'd2, 16'h0042, 4'd0, 4'd0, 1'b1, 4'd9, 1'b1, 5'b11111, 5'b10101);
    cyc(1'b1, 1'b1, 4'd2, 16'h1234, 4'd2, 4'd9, 1'b1, 4'd2, 1'b1, 5'b11111, 5'b11111);
    rd(4'd2, 4'd9);
    chk("mid_rst_r2", 32'(bus.readData1), 32'h0);
    chk("mid_rst_busy2", 32'(bus.srcBusy), 32'h0);
    chk("mid_rst_busy9", 32'(bus.dstBusy), 32'h0);
    chk("mid_rst_flags", 32'(bus.readFlags), 32'h0);

    rd(4'd0, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
